// File: rtl/time_set_controller.sv
// Time/alarm setting controller: debounces four buttons and runs the edit FSM
// that produces edit values, load strobes, count enable and blink phase.
module time_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLK_50,
  input  logic       nCR,
  input  logic       tick_1hz,
  input  logic [1:0] settingMode,
  input  logic [3:0] settingButtons,
  input  logic [4:0] time_hour,
  input  logic [5:0] time_min,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  output logic [4:0] edit_hour,
  output logic [5:0] edit_min,
  output logic       load_time,
  output logic       load_alarm,
  output logic       count_en,
  output logic [1:0] field_sel,
  output logic       blink
);

  localparam int unsigned CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned NBTN     = 4;
  localparam int unsigned BTN_INC  = 0;
  localparam int unsigned BTN_DEC  = 1;
  localparam int unsigned BTN_NEXT = 2;
  localparam int unsigned BTN_CONF = 3;

  typedef enum logic [1:0] {IDLE, EDIT_HOUR, EDIT_MIN, COMMIT} state_t;

  logic [NBTN-1:0] sync1, sync2, db, db_d, press;
  logic [CW-1:0]   cnt [NBTN];

  // Synchronize, then accept a new level only after it has held steadily
  always_ff @(posedge CLK_50) begin
    if (!nCR) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
    end else begin
      sync1 <= settingButtons;
      sync2 <= sync1;
      db_d  <= db;
      for (int i = 0; i < NBTN; i++) begin
        if (sync2[i] != db[i]) begin
          if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            db[i]  <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign press = db & ~db_d;

  state_t     state, state_nxt;
  logic       arm, arm_nxt;
  logic       tgt_alarm, tgt_alarm_nxt;
  logic [4:0] edit_hour_nxt, seed_hour;
  logic [5:0] edit_min_nxt, seed_min;
  logic       blink_nxt, load_time_nxt, load_alarm_nxt, count_en_nxt;
  logic [1:0] field_sel_nxt, tgt_code;
  logic       run_mode;

  always_ff @(posedge CLK_50) begin
    if (!nCR) begin
      state      <= IDLE;
      arm        <= 1'b1;
      tgt_alarm  <= 1'b0;
      edit_hour  <= '0;
      edit_min   <= '0;
      load_time  <= 1'b0;
      load_alarm <= 1'b0;
      count_en   <= 1'b1;
      field_sel  <= 2'b00;
      blink      <= 1'b1;
    end else begin
      state      <= state_nxt;
      arm        <= arm_nxt;
      tgt_alarm  <= tgt_alarm_nxt;
      edit_hour  <= edit_hour_nxt;
      edit_min   <= edit_min_nxt;
      load_time  <= load_time_nxt;
      load_alarm <= load_alarm_nxt;
      count_en   <= count_en_nxt;
      field_sel  <= field_sel_nxt;
      blink      <= blink_nxt;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_nxt     = state;
    arm_nxt       = arm;
    tgt_alarm_nxt = tgt_alarm;
    edit_hour_nxt = edit_hour;
    edit_min_nxt  = edit_min;
    blink_nxt     = blink;
    run_mode      = (settingMode[0] == settingMode[1]);
    tgt_code      = tgt_alarm ? 2'b10 : 2'b01;
    seed_hour     = settingMode[1] ? alarm_hour : time_hour;
    seed_min      = settingMode[1] ? alarm_min  : time_min;

    if (run_mode) arm_nxt = 1'b1;

    case (state)
      IDLE: begin
        if (arm && !run_mode) begin
          tgt_alarm_nxt = settingMode[1];
          arm_nxt       = 1'b0;
          state_nxt     = EDIT_HOUR;
          edit_hour_nxt = (seed_hour > 5'd23) ? 5'd0 : seed_hour;
          edit_min_nxt  = (seed_min > 6'd59) ? 6'd0 : seed_min;
          blink_nxt     = 1'b1;
        end
      end
      EDIT_HOUR, EDIT_MIN: begin
        if (settingMode != tgt_code) begin
          state_nxt = IDLE;
        end else if (press[BTN_CONF]) begin
          state_nxt = COMMIT;
        end else if (press[BTN_NEXT]) begin
          state_nxt = (state == EDIT_HOUR) ? EDIT_MIN : EDIT_HOUR;
          blink_nxt = 1'b1;
        end else if (press[BTN_INC]) begin
          blink_nxt = 1'b1;
          if (state == EDIT_HOUR)
            edit_hour_nxt = (edit_hour == 5'd23) ? 5'd0 : edit_hour + 5'd1;
          else
            edit_min_nxt = (edit_min == 6'd59) ? 6'd0 : edit_min + 6'd1;
        end else if (press[BTN_DEC]) begin
          blink_nxt = 1'b1;
          if (state == EDIT_HOUR)
            edit_hour_nxt = (edit_hour == 5'd0) ? 5'd23 : edit_hour - 5'd1;
          else
            edit_min_nxt = (edit_min == 6'd0) ? 6'd59 : edit_min - 6'd1;
        end else if (tick_1hz) begin
          blink_nxt = ~blink;
        end
      end
      COMMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs follow the state being entered so they line up with it
    if (state_nxt == IDLE || state_nxt == COMMIT) blink_nxt = 1'b1;
    case (state_nxt)
      EDIT_HOUR: field_sel_nxt = 2'b01;
      EDIT_MIN:  field_sel_nxt = 2'b10;
      default:   field_sel_nxt = 2'b00;
    endcase
    load_time_nxt  = (state_nxt == COMMIT) && !tgt_alarm_nxt;
    load_alarm_nxt = (state_nxt == COMMIT) &&  tgt_alarm_nxt;
    count_en_nxt   = !((state_nxt != IDLE) && !tgt_alarm_nxt);
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with a short debounce window.
module tb_time_set_controller;

  logic       clk = 1'b0;
  logic       nCR;
  logic       tick_1hz;
  logic [1:0] settingMode;
  logic [3:0] settingButtons;
  logic [4:0] time_hour, alarm_hour, edit_hour;
  logic [5:0] time_min, alarm_min, edit_min;
  logic       load_time, load_alarm, count_en, blink;
  logic [1:0] field_sel;

  int total = 0;
  int bad   = 0;
  int lt_cnt = 0, la_cnt = 0, ce_low = 0;
  logic [4:0] cap_hour;
  logic [5:0] cap_min;

  time_set_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK_50(clk), .nCR(nCR), .tick_1hz(tick_1hz), .settingMode(settingMode),
    .settingButtons(settingButtons), .time_hour(time_hour), .time_min(time_min),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .edit_hour(edit_hour),
    .edit_min(edit_min), .load_time(load_time), .load_alarm(load_alarm),
    .count_en(count_en), .field_sel(field_sel), .blink(blink)
  );

  always #10 clk = ~clk;

  // Strobe and run-enable monitor
  always @(negedge clk) begin
    if (load_time) begin
      lt_cnt++;
      cap_hour = edit_hour;
      cap_min  = edit_min;
    end
    if (load_alarm) la_cnt++;
    if (!count_en) ce_low++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold buttons long enough to debounce, then release fully
  task automatic press(input logic [3:0] b);
    settingButtons = b;
    cycles(8);
    settingButtons = 4'b0000;
    cycles(8);
  endtask

  task automatic enter(input logic [1:0] mode);
    settingMode = 2'b00;
    cycles(2);
    settingMode = mode;
    cycles(1);
  endtask

  task automatic test_reset;
    nCR = 1'b0;
    cycles(2);
    total++;
    if ({edit_hour, edit_min, load_time, load_alarm, count_en, field_sel, blink} !==
        {5'd0, 6'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1}) begin
      bad++;
      $display("FAIL reset: got h=%0d m=%0d lt=%b la=%b ce=%b fs=%b bl=%b", edit_hour, edit_min,
               load_time, load_alarm, count_en, field_sel, blink);
    end
    nCR = 1'b1;
    cycles(2);
  endtask

  task automatic test_entry;
    time_hour = 5'd12; time_min = 6'd34;
    enter(2'b01);
    total++;
    if ({edit_hour, edit_min, count_en, field_sel, blink} !== {5'd12, 6'd34, 1'b0, 2'b01, 1'b1}) begin
      bad++;
      $display("FAIL entry: got %0d:%0d ce=%b fs=%b bl=%b, want 12:34 ce=0 fs=01 bl=1",
               edit_hour, edit_min, count_en, field_sel, blink);
    end
    settingMode = 2'b00;
    cycles(2);
    total++;
    if ({field_sel, count_en} !== {2'b00, 1'b1} || lt_cnt !== 0) begin
      bad++;
      $display("FAIL entry_abort: fs=%b ce=%b lt_cnt=%0d, want 00 1 0", field_sel, count_en, lt_cnt);
    end
  endtask

  task automatic test_wrap_commit;
    time_hour = 5'd23; time_min = 6'd0;
    enter(2'b01);
    press(4'b0001);
    total++;
    if (edit_hour !== 5'd0) begin
      bad++;
      $display("FAIL hour_inc_wrap: got %0d want 0", edit_hour);
    end
    press(4'b0100);
    press(4'b0010);
    total++;
    if (edit_min !== 6'd59 || field_sel !== 2'b10) begin
      bad++;
      $display("FAIL min_dec_wrap: got m=%0d fs=%b want 59 10", edit_min, field_sel);
    end
    press(4'b0001);
    total++;
    if (edit_min !== 6'd0) begin
      bad++;
      $display("FAIL min_inc_wrap: got %0d want 0", edit_min);
    end
    press(4'b0010);
    lt_cnt = 0;
    press(4'b1000);
    total++;
    if (lt_cnt !== 1 || cap_hour !== 5'd0 || cap_min !== 6'd59) begin
      bad++;
      $display("FAIL commit: lt_cnt=%0d val=%0d:%0d want 1 0:59", lt_cnt, cap_hour, cap_min);
    end
    total++;
    if (count_en !== 1'b1 || field_sel !== 2'b00 || load_alarm !== 1'b0) begin
      bad++;
      $display("FAIL post_commit: ce=%b fs=%b la=%b want 1 00 0", count_en, field_sel, load_alarm);
    end
    press(4'b0001);
    press(4'b1000);
    total++;
    if (edit_hour !== 5'd0 || edit_min !== 6'd59 || field_sel !== 2'b00 || lt_cnt !== 1) begin
      bad++;
      $display("FAIL no_rearm: got %0d:%0d fs=%b lt_cnt=%0d want 0:59 00 1",
               edit_hour, edit_min, field_sel, lt_cnt);
    end
    time_hour = 5'd8; time_min = 6'd15;
    enter(2'b01);
    total++;
    if (field_sel !== 2'b01 || edit_hour !== 5'd8 || edit_min !== 6'd15) begin
      bad++;
      $display("FAIL rearm: fs=%b got %0d:%0d want 01 8:15", field_sel, edit_hour, edit_min);
    end
    settingMode = 2'b00;
    cycles(2);
  endtask

  task automatic test_alarm_abort;
    alarm_hour = 5'd6; alarm_min = 6'd30;
    la_cnt = 0; ce_low = 0;
    enter(2'b10);
    total++;
    if ({edit_hour, edit_min, field_sel, count_en} !== {5'd6, 6'd30, 2'b01, 1'b1}) begin
      bad++;
      $display("FAIL alarm_entry: got %0d:%0d fs=%b ce=%b want 6:30 01 1",
               edit_hour, edit_min, field_sel, count_en);
    end
    press(4'b0001);
    total++;
    if (edit_hour !== 5'd7) begin
      bad++;
      $display("FAIL alarm_inc: got %0d want 7", edit_hour);
    end
    settingMode = 2'b00;
    cycles(1);
    total++;
    if (field_sel !== 2'b00) begin
      bad++;
      $display("FAIL alarm_abort: fs=%b want 00", field_sel);
    end
    cycles(3);
    total++;
    if (la_cnt !== 0 || ce_low !== 0) begin
      bad++;
      $display("FAIL alarm_strobe: la_cnt=%0d ce_low=%0d want 0 0", la_cnt, ce_low);
    end
  endtask

  task automatic test_bounce_blink;
    time_hour = 5'd5; time_min = 6'd10;
    enter(2'b01);
    for (int i = 0; i < 4; i++) begin
      settingButtons = 4'b0001; cycles(3);
      settingButtons = 4'b0000; cycles(3);
    end
    cycles(8);
    total++;
    if (edit_hour !== 5'd5) begin
      bad++;
      $display("FAIL bounce: got %0d want 5", edit_hour);
    end
    settingButtons = 4'b0001; cycles(5);
    settingButtons = 4'b0000; cycles(10);
    total++;
    if (edit_hour !== 5'd6) begin
      bad++;
      $display("FAIL hold5: got %0d want 6", edit_hour);
    end
    tick_1hz = 1'b1; cycles(1);
    tick_1hz = 1'b0; cycles(1);
    total++;
    if (blink !== 1'b0) begin
      bad++;
      $display("FAIL blink_tick: got %b want 0", blink);
    end
    lt_cnt = 0;
    press(4'b1001);
    total++;
    if (lt_cnt !== 1 || cap_hour !== 5'd6 || cap_min !== 6'd10 || edit_hour !== 5'd6) begin
      bad++;
      $display("FAIL inc_confirm: lt_cnt=%0d val=%0d:%0d eh=%0d want 1 6:10 6",
               lt_cnt, cap_hour, cap_min, edit_hour);
    end
    total++;
    if (blink !== 1'b1) begin
      bad++;
      $display("FAIL blink_idle: got %b want 1", blink);
    end
    settingMode = 2'b00;
    cycles(2);
  endtask

  task automatic test_reset_mid_edit;
    time_hour = 5'd25; time_min = 6'd61;
    enter(2'b01);
    total++;
    if (edit_hour !== 5'd0 || edit_min !== 6'd0) begin
      bad++;
      $display("FAIL clamp: got %0d:%0d want 0:0", edit_hour, edit_min);
    end
    press(4'b0010);
    total++;
    if (edit_hour !== 5'd23) begin
      bad++;
      $display("FAIL hour_dec_wrap: got %0d want 23", edit_hour);
    end
    press(4'b0100);
    press(4'b0001);
    total++;
    if (field_sel !== 2'b10 || edit_min !== 6'd1) begin
      bad++;
      $display("FAIL edit_min: fs=%b m=%0d want 10 1", field_sel, edit_min);
    end
    lt_cnt = 0;
    nCR = 1'b0;
    cycles(1);
    total++;
    if ({edit_hour, edit_min, load_time, load_alarm, count_en, field_sel, blink} !==
        {5'd0, 6'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid: got h=%0d m=%0d lt=%b la=%b ce=%b fs=%b bl=%b", edit_hour, edit_min,
               load_time, load_alarm, count_en, field_sel, blink);
    end
    settingMode = 2'b00;
    cycles(1);
    nCR = 1'b1;
    cycles(4);
    total++;
    if (lt_cnt !== 0 || field_sel !== 2'b00) begin
      bad++;
      $display("FAIL reset_strobe: lt_cnt=%0d fs=%b want 0 00", lt_cnt, field_sel);
    end
  endtask

  initial begin
    nCR = 1'b0; tick_1hz = 1'b0; settingMode = 2'b00; settingButtons = 4'b0000;
    time_hour = 5'd0; time_min = 6'd0; alarm_hour = 5'd0; alarm_min = 6'd0;
    cycles(1);
    test_reset;
    test_entry;
    test_wrap_commit;
    test_alarm_abort;
    test_bounce_blink;
    test_reset_mid_edit;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_set_controller.md
TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), number of consecutive stable cycles before a button level is accepted.
REQ-002 SHALL have port CLK_50  in  1  sole clock; all flops rising-edge.
REQ-003 SHALL have port nCR  in  1  reset; one clock, reset is synchronous and active-low.
REQ-004 SHALL have port tick_1hz  in  1  one-cycle pulse per second from the clock prescaler.
REQ-005 SHALL have port settingMode  in  2  00 run, 01 set time, 10 set alarm, 11 treated as 00.
REQ-006 SHALL have port settingButtons  in  4  raw asynchronous levels: [0] inc, [1] dec, [2] next field, [3] confirm.
REQ-007 SHALL have ports time_hour/alarm_hour  in  5 each and time_min/alarm_min  in  6 each  current counter values, binary.
REQ-008 SHALL have ports edit_hour  out  5 and edit_min  out  6  values being edited, binary.
REQ-009 SHALL have ports load_time, load_alarm  out  1 each  one-cycle strobes that commit edit_hour/edit_min into the target counters.
REQ-010 SHALL have port count_en  out  1  run enable for the time counters.
REQ-011 SHALL have port field_sel  out  2  00 none, 01 hour, 10 minute; the field under edit.
REQ-012 SHALL have port blink  out  1  display blanking phase for the selected field, 1 = show.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer, then a per-button counter; the debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
REQ-014 SHALL produce a one-cycle press pulse on the 0->1 transition of each debounced level. A held button SHALL produce no repeat pulses.
REQ-015 SHALL implement states IDLE, EDIT_HOUR, EDIT_MIN, COMMIT.
REQ-016 SHALL track an arm flag, set while settingMode is 00/11. In IDLE with arm=1 and settingMode 01 or 10, it SHALL latch the target (time/alarm), clear arm, and go to EDIT_HOUR.
REQ-017 On that entry cycle, edit regs SHALL be seeded from time_* (target time) or alarm_* (target alarm).
REQ-018 Press priority per cycle SHALL be confirm > next > inc > dec; only the highest-priority press SHALL be acted on, and the others are dropped.
REQ-019 In EDIT_*: inc SHALL add 1 to the selected field (hour 23->0, min 59->0); dec SHALL subtract 1 (hour 0->23, min 0->59).
REQ-020 In EDIT_*: next SHALL toggle between EDIT_HOUR and EDIT_MIN; confirm SHALL go to COMMIT.
REQ-021 COMMIT SHALL last exactly one cycle and assert load_time or load_alarm per target, then return to IDLE. Edit regs SHALL be held stable during the strobe.
REQ-022 If settingMode changes from the latched target in EDIT_* (to any other value), the block SHALL go to IDLE on the next edge with no load strobe (abort).
REQ-023 After COMMIT or abort, the block SHALL not re-enter edit until settingMode has returned to 00/11 (arm re-set).
REQ-024 Press pulses SHALL be ignored in IDLE and COMMIT.
REQ-025 count_en SHALL be 0 while in EDIT_* or COMMIT with target time; it SHALL be 1 otherwise, so the alarm is edited while time keeps running.
REQ-026 field_sel SHALL be 01 in EDIT_HOUR, 10 in EDIT_MIN, and 00 elsewhere.
REQ-027 blink SHALL be set to 1 on edit entry and on every accepted press, and SHALL toggle on each tick_1hz while in EDIT_*. It SHALL be 1 in IDLE/COMMIT.
REQ-028 Out-of-range seed values (hour>23, min>59) SHALL be clamped to 0 on entry.

Reset
REQ-029 With nCR=0 at a clock edge: state IDLE, arm=1, edit_hour=0, edit_min=0, load_time=0, load_alarm=0, count_en=1, field_sel=00, blink=1, synchronizers/debounce counters/debounced levels all 0.
REQ-030 Reset mid-edit or during COMMIT SHALL abandon the edit with no load strobe on the reset cycle or after.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Reset, settingMode 00->01, time=12:34 -> EDIT_HOUR, edit=12:34, count_en=0, field_sel=01.
REQ-032 Edit hour=23, inc press -> edit_hour=0; next then dec with min=0 -> edit_min=59, field_sel=10.
REQ-033 Confirm -> load_time high for exactly one cycle with edit values; count_en=1 afterward; further presses ignored until settingMode returns to 00.
REQ-034 Mode 10 with alarm=06:30; change settingMode to 00 mid-edit -> IDLE, no load_alarm; count_en stays 1 throughout.
REQ-035 inc bouncing with 3-cycle pulses -> no press; a 5-cycle hold -> one increment; inc+confirm in the same cycle -> commit only.
REQ-036 nCR=0 during EDIT_MIN -> all outputs at REQ-029 values on the next edge, no strobe.
